// File: rtl/mode_counter.sv
// mode_counter: modulo-(LIMIT+1) up/down counter whose step size changes only at wrap or load
module mode_counter #(
    parameter int WIDTH  = 15,
    parameter int MODE_W = 3,
    parameter int LIMIT  = 22499
) (
    input  logic              clk,
    input  logic              resetIn,
    input  logic              enb,
    input  logic [MODE_W-1:0] mode,
    input  logic              dir,
    input  logic              load,
    input  logic [WIDTH-1:0]  loadVal,
    output logic [WIDTH-1:0]  cout,
    output logic              resetOut,
    output logic [MODE_W-1:0] modeActive
);
    localparam logic [WIDTH:0] LIM      = (WIDTH+1)'(LIMIT);
    localparam logic [WIDTH:0] WRAP_ADD = (WIDTH+1)'(LIMIT + 1);
    logic [MODE_W-1:0] pending;
    logic [WIDTH:0]    cur, step, up_sum;
    logic [WIDTH-1:0]  dn_sum, nxt, load_c;
    logic              up_wrap, dn_wrap, wrap;
    always_comb begin
        cur     = {1'b0, cout};
        step    = (WIDTH+1)'(modeActive);
        up_sum  = cur + step;
        dn_sum  = WIDTH'(cur + WRAP_ADD - step);
        up_wrap = up_sum > LIM;
        dn_wrap = cur < step;
        wrap    = dir ? up_wrap : dn_wrap;
        nxt     = dir ? (up_wrap ? WIDTH'(up_sum - WRAP_ADD) : up_sum[WIDTH-1:0])
                      : (dn_wrap ? dn_sum : WIDTH'(cur - step));
        load_c  = ({1'b0, loadVal} > LIM) ? LIM[WIDTH-1:0] : loadVal;
    end
    // modeActive only follows the pending mode at period boundaries (wrap or load)
    always_ff @(posedge clk) begin
        if (resetIn) begin
            cout       <= '0;
            resetOut   <= 1'b0;
            modeActive <= mode;
            pending    <= mode;
        end else begin
            pending  <= mode;
            resetOut <= 1'b0;
            if (load) begin
                cout       <= load_c;
                modeActive <= pending;
            end else if (enb) begin
                cout     <= nxt;
                resetOut <= wrap;
                if (wrap) modeActive <= pending;
            end
        end
    end
endmodule

// File: tb/tb_mode_counter.sv
// tb_mode_counter: directed vectors with a scoreboard queue checked by an independent monitor
module tb_mode_counter;
    logic        clk = 1'b0;
    logic        resetIn = 1'b1, enb = 1'b0, dir = 1'b1, load = 1'b0;
    logic [2:0]  mode = 3'd1;
    logic [14:0] loadVal = '0;
    logic [14:0] cout;
    logic        resetOut;
    logic [2:0]  modeActive;
    typedef struct {
        logic [14:0] c;
        logic        r;
        logic [2:0]  m;
        string       name;
    } exp_t;
    exp_t q[$];
    int checks = 0, failures = 0;
    mode_counter dut (
        .clk(clk), .resetIn(resetIn), .enb(enb), .mode(mode), .dir(dir), .load(load),
        .loadVal(loadVal), .cout(cout), .resetOut(resetOut), .modeActive(modeActive)
    );
    always #5 clk = ~clk;
    // each pushed entry describes the outputs after the next rising edge
    task automatic cyc(input logic r, input logic e, input logic d, input logic ld,
                       input logic [14:0] lv, input logic [2:0] m,
                       input logic [14:0] ec, input logic er, input logic [2:0] em,
                       input string nm);
        exp_t x;
        @(negedge clk);
        resetIn = r; enb = e; dir = d; load = ld; loadVal = lv; mode = m;
        x.c = ec; x.r = er; x.m = em; x.name = nm;
        q.push_back(x);
    endtask
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            checks++;
            if (cout !== x.c || resetOut !== x.r || modeActive !== x.m) begin
                failures++;
                $display("FAIL %s: got cout=%0d resetOut=%0b modeActive=%0d, expected cout=%0d resetOut=%0b modeActive=%0d",
                         x.name, cout, resetOut, modeActive, x.c, x.r, x.m);
            end
        end
    end
    initial begin
        cyc(1, 0, 1, 0, 0, 1, 0, 0, 1, "reset");
        for (int i = 0; i < 22501; i++)
            cyc(0, 1, 1, 0, 0, 1, 15'((i + 1) % 22500), ((i + 1) % 22500) == 0, 1, "full_period");
        cyc(0, 0, 1, 0, 0, 5, 1, 0, 1, "hold_en0");
        cyc(0, 1, 1, 1, 15'd30000, 5, 22499, 0, 5, "load_clamp");
        cyc(0, 0, 1, 0, 0, 3, 22499, 0, 5, "hold_pre_load");
        cyc(0, 0, 1, 1, 15'd22498, 3, 22498, 0, 3, "load_22498");
        cyc(0, 1, 1, 0, 0, 3, 1, 1, 3, "up_wrap_step3");
        cyc(0, 1, 1, 0, 0, 3, 4, 0, 3, "after_wrap");
        cyc(0, 0, 1, 0, 0, 1, 4, 0, 3, "hold_mode1");
        cyc(0, 0, 1, 1, 0, 1, 0, 0, 1, "load_0");
        cyc(0, 1, 0, 0, 0, 1, 22499, 1, 1, "down_wrap");
        cyc(0, 1, 0, 0, 0, 1, 22498, 0, 1, "down_step");
        cyc(0, 0, 0, 0, 0, 7, 22498, 0, 1, "en0_mode7");
        cyc(0, 0, 0, 0, 0, 1, 22498, 0, 1, "en0_mode1");
        cyc(0, 0, 1, 1, 15'd100, 1, 100, 0, 1, "load_100");
        for (int k = 1; k <= 22400; k++)
            cyc(0, 1, 1, 0, 0, 2, 15'((100 + k) % 22500), k == 22400, k == 22400 ? 3'd2 : 3'd1, "midperiod_mode");
        cyc(0, 1, 1, 0, 0, 2, 2, 0, 2, "step2_a");
        cyc(0, 1, 1, 0, 0, 2, 4, 0, 2, "step2_b");
        cyc(0, 1, 0, 0, 0, 2, 2, 0, 2, "dir_flip_down");
        cyc(0, 1, 0, 0, 0, 2, 0, 0, 2, "down_to_0");
        cyc(0, 1, 0, 0, 0, 2, 22498, 1, 2, "down_wrap_step2");
        cyc(0, 1, 1, 0, 0, 2, 0, 1, 2, "up_wrap_exact");
        cyc(0, 1, 1, 0, 0, 2, 2, 0, 2, "up_after_wrap");
        cyc(0, 0, 1, 0, 0, 0, 2, 0, 2, "hold_mode0");
        cyc(0, 0, 1, 1, 15'd7, 0, 7, 0, 0, "load_mode0");
        cyc(0, 1, 1, 0, 0, 0, 7, 0, 0, "step0_up");
        cyc(0, 1, 0, 0, 0, 0, 7, 0, 0, "step0_down");
        cyc(0, 1, 1, 1, 15'd22499, 0, 22499, 0, 0, "load_limit");
        cyc(0, 1, 1, 0, 0, 0, 22499, 0, 0, "step0_at_limit");
        cyc(0, 0, 1, 1, 15'd5000, 2, 5000, 0, 0, "load_5000");
        cyc(1, 1, 1, 1, 15'd9, 4, 0, 0, 4, "reset_priority");
        cyc(0, 1, 1, 0, 0, 6, 4, 0, 4, "restart");
        cyc(0, 1, 1, 0, 0, 6, 8, 0, 4, "restart_2");
        for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 Parameter WIDTH, default 15, counter and load-value width in bits.
REQ-002 Parameter MODE_W, default 3, mode field width in bits.
REQ-003 Parameter LIMIT, default 22499, terminal count; SHALL satisfy LIMIT < 2^WIDTH and 2^MODE_W-1 <= LIMIT+1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 resetIn  input  1  synchronous, active-high reset.
REQ-006 enb  input  1  count enable; count advances only on cycles where enb=1.
REQ-007 mode  input  MODE_W  requested step size (0 = hold); sampled every cycle into a pending register.
REQ-008 dir  input  1  count direction: 1 = up, 0 = down.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 loadVal  input  WIDTH  value written to cout on load.
REQ-011 cout  output  WIDTH  registered count value, always within 0..LIMIT.
REQ-012 resetOut  output  1  registered one-cycle wrap pulse.
REQ-013 modeActive  output  MODE_W  registered step size currently in use.

Function
REQ-014 Step size SHALL be modeActive; modeActive=0 SHALL leave cout unchanged and never assert resetOut.
REQ-015 Up count: next = cout+step computed at WIDTH+1 bits; if next > LIMIT then cout <= next-(LIMIT+1) and the cycle is a wrap; otherwise cout <= next.
REQ-016 Down count: if cout >= step then cout <= cout-step; otherwise cout <= cout+(LIMIT+1)-step at WIDTH+1 bits and the cycle is a wrap.
REQ-017 resetOut SHALL be 1 in the cycle following a wrap update and 0 in all other cycles; it is never held high for two consecutive cycles unless two consecutive wraps occur.
REQ-018 The pending register SHALL capture mode every cycle.
REQ-019 modeActive SHALL take the pending value only on a wrap cycle, or on a load cycle; cout and modeActive SHALL update in the same edge.
REQ-020 A mode change in the middle of a period SHALL NOT alter the step size until the next wrap or load.
REQ-021 Load SHALL take priority over counting: when load=1, cout <= min(loadVal, LIMIT) regardless of enb, dir or mode.
REQ-022 A load cycle SHALL NOT be a wrap cycle; resetOut SHALL be 0 in the cycle following a load.
REQ-023 enb=0 with load=0 SHALL hold cout and modeActive and drive resetOut to 0; the pending register still updates.
REQ-024 A dir change SHALL take effect on the same cycle it is sampled, with no wrap generated by the change itself.
REQ-025 The latency from an enabled edge to the updated cout and resetOut SHALL be one cycle; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-026 When resetIn=1 at a rising edge: cout <= 0, resetOut <= 0, modeActive <= mode, pending <= mode.
REQ-027 resetIn SHALL have priority over load and enb.
REQ-028 Counting SHALL resume on the first edge after resetIn falls, with no residual state from before reset.
REQ-029 A reset asserted in the middle of a period SHALL discard any pending-mode change.

Verification (WIDTH=15, MODE_W=3, LIMIT=22499)
REQ-030 Reset with mode=1, then enb=1, dir=1 for 22500 cycles -> cout steps 0,1,…,22499,0; resetOut is high for exactly one cycle, after the 22499->0 update.
REQ-031 Load 22498 with mode=3 applied by the load, then one enabled up cycle -> cout=1 and resetOut=1 in the next cycle.
REQ-032 cout=0, modeActive=1, dir=0, one enabled cycle -> cout=22499 and resetOut pulses once.
REQ-033 At cout=100 with modeActive=1, set mode=2 -> step remains 1 up to the wrap; then cout=0 and modeActive=2 on the same edge, and counting continues 2,4,….
REQ-034 load=1 with loadVal=30000 and enb=1 -> cout=22499, resetOut=0; modeActive equals the pending mode.
REQ-035 resetIn=1 for one cycle at cout=5000 with enb=1 and load=1 -> cout=0, resetOut=0, modeActive=mode; counting restarts from 0 on the next edge.
